// File: rtl/i2s_transceiver.sv
// i2s_transceiver
//
// I2S bus master and full-duplex stereo sample transceiver. Runs directly on the
// bit clock: generates LRCLK framing, serializes playback pairs onto sdout and
// deserializes sdin into parallel stereo samples. Standard I2S framing: data is
// delayed one slot after the LRCLK edge and sent MSB first.
//
// Parameters
//   WIDTH        bits per channel sample (8..32); a frame is 2*WIDTH slots
//
// Ports
//   clk          bit clock, all state updates on its rising edge
//   reset        asynchronous active-high reset
//   tx_left      left playback sample, accepted when tx_ready && tx_valid
//   tx_right     right playback sample
//   tx_valid     playback pair present; only looked at while tx_ready = 1
//   tx_ready     one-cycle pulse per frame (slot 0); pair accepted this cycle
//   tx_underrun  sticky flag, set when tx_ready was high without tx_valid
//   rx_left      last complete captured left sample
//   rx_right     last complete captured right sample
//   rx_valid     one-cycle pulse when rx_left/rx_right have just updated
//   lrclk        word select, 0 = left channel, 1 = right channel
//   sdout        serial data to the DAC
//   sdin         serial data from the ADC / microphone
module i2s_transceiver #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] tx_left,
  input  logic [WIDTH-1:0] tx_right,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_underrun,
  output logic [WIDTH-1:0] rx_left,
  output logic [WIDTH-1:0] rx_right,
  output logic             rx_valid,
  output logic             lrclk,
  output logic             sdout,
  input  logic             sdin
);

  localparam int unsigned F     = 2 * WIDTH;
  localparam int unsigned SlotW = $clog2(F);

  localparam logic [SlotW-1:0] SlotLast  = SlotW'(F - 1);
  localparam logic [SlotW-1:0] SlotRight = SlotW'(WIDTH);

  // Slot counter
  logic [SlotW-1:0] slot_q, slot_d;
  logic             frame_start;

  // TX: bit F-1 of the shifter is the line driver, so sdout is a flop output.
  logic [F-1:0] tx_shift_q, tx_shift_d;
  logic         tx_underrun_q, tx_underrun_d;

  // RX: holds the bits of slots 1..F-1; the slot-0 bit is still on sdin when
  // the frame is closed, so it is appended combinationally at that edge.
  logic [F-2:0]     rx_shift_q, rx_shift_d;
  logic [F-1:0]     rx_frame;
  logic             rx_armed_q, rx_armed_d;
  logic [WIDTH-1:0] rx_left_q, rx_left_d;
  logic [WIDTH-1:0] rx_right_q, rx_right_d;
  logic             rx_valid_q, rx_valid_d;

  assign frame_start = (slot_q == '0);
  assign rx_frame    = {rx_shift_q, sdin};

  always_comb begin
    slot_d = slot_q + SlotW'(1);
    if (slot_q == SlotLast) begin
      slot_d = '0;
    end
  end

  always_comb begin
    tx_shift_d    = {tx_shift_q[F-2:0], 1'b0};
    tx_underrun_d = tx_underrun_q;
    if (frame_start) begin
      // A missing pair is sent as silence for the whole frame.
      tx_shift_d = tx_valid ? {tx_left, tx_right} : '0;
      if (!tx_valid) begin
        tx_underrun_d = 1'b1;
      end
    end
  end

  always_comb begin
    rx_shift_d = {rx_shift_q[F-3:0], sdin};
    rx_armed_d = rx_armed_q;
    rx_left_d  = rx_left_q;
    rx_right_d = rx_right_q;
    rx_valid_d = 1'b0;
    if (frame_start) begin
      // The first slot 0 after reset closes a partial frame: arm only.
      rx_armed_d = 1'b1;
      if (rx_armed_q) begin
        rx_left_d  = rx_frame[F-1:WIDTH];
        rx_right_d = rx_frame[WIDTH-1:0];
        rx_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q        <= SlotLast;
      tx_shift_q    <= '0;
      tx_underrun_q <= 1'b0;
      rx_shift_q    <= '0;
      rx_armed_q    <= 1'b0;
      rx_left_q     <= '0;
      rx_right_q    <= '0;
      rx_valid_q    <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      tx_shift_q    <= tx_shift_d;
      tx_underrun_q <= tx_underrun_d;
      rx_shift_q    <= rx_shift_d;
      rx_armed_q    <= rx_armed_d;
      rx_left_q     <= rx_left_d;
      rx_right_q    <= rx_right_d;
      rx_valid_q    <= rx_valid_d;
    end
  end

  assign tx_ready    = frame_start;
  assign lrclk       = (slot_q >= SlotRight);
  assign sdout       = tx_shift_q[F-1];
  assign tx_underrun = tx_underrun_q;
  assign rx_left     = rx_left_q;
  assign rx_right    = rx_right_q;
  assign rx_valid    = rx_valid_q;

endmodule

// File: tb/tb_i2s_transceiver.sv
// Self-checking bench for i2s_transceiver (WIDTH=16 and WIDTH=8 instances).
// The reference model keeps the history of accepted playback words and of
// every sdin bit, indexed by cycle since reset, and derives each output from
// the framing rules with plain arithmetic.
module tb_i2s_transceiver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH = 16 instance
  logic        reset16;
  logic [15:0] tl16, tr16, rl16, rr16;
  logic        tv16, rdy16, und16, rv16, lr16, so16, si16, rnd16;
  bit          loop16;
  assign si16 = loop16 ? so16 : rnd16;

  i2s_transceiver #(.WIDTH(16)) u_dut16 (
    .clk        (clk),
    .reset      (reset16),
    .tx_left    (tl16),
    .tx_right   (tr16),
    .tx_valid   (tv16),
    .tx_ready   (rdy16),
    .tx_underrun(und16),
    .rx_left    (rl16),
    .rx_right   (rr16),
    .rx_valid   (rv16),
    .lrclk      (lr16),
    .sdout      (so16),
    .sdin       (si16)
  );

  // WIDTH = 8 instance
  logic        reset8;
  logic [7:0]  tl8, tr8, rl8, rr8;
  logic        tv8, rdy8, und8, rv8, lr8, so8, si8, rnd8;
  bit          loop8;
  assign si8 = loop8 ? so8 : rnd8;

  i2s_transceiver #(.WIDTH(8)) u_dut8 (
    .clk        (clk),
    .reset      (reset8),
    .tx_left    (tl8),
    .tx_right   (tr8),
    .tx_valid   (tv8),
    .tx_ready   (rdy8),
    .tx_underrun(und8),
    .rx_left    (rl8),
    .rx_right   (rr8),
    .rx_valid   (rv8),
    .lrclk      (lr8),
    .sdout      (so8),
    .sdin       (si8)
  );

  // Model state
  int          w_cur;
  int          cyc;
  logic [63:0] tx_hist[int];
  bit          sin_hist[int];
  logic [31:0] exp_rl, exp_rr;
  bit          exp_und;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s w=%0d cyc=%0d got=%0h exp=%0h", tag, w_cur, cyc, got, exp);
    end
  endtask

  task automatic sample(output logic lr, output logic so, output logic rdy, output logic und,
                        output logic rv, output logic [31:0] rl, output logic [31:0] rr);
    if (w_cur == 16) begin
      lr = lr16; so = so16; rdy = rdy16; und = und16; rv = rv16;
      rl = {16'd0, rl16}; rr = {16'd0, rr16};
    end else begin
      lr = lr8; so = so8; rdy = rdy8; und = und8; rv = rv8;
      rl = {24'd0, rl8}; rr = {24'd0, rr8};
    end
  endtask

  task automatic set_reset(input logic v);
    if (w_cur == 16) reset16 = v;
    else reset8 = v;
  endtask

  task automatic model_clear();
    tx_hist.delete();
    sin_hist.delete();
    exp_rl  = '0;
    exp_rr  = '0;
    exp_und = 1'b0;
    cyc     = 0;
  endtask

  task automatic check_reset_vals();
    logic lr, so, rdy, und, rv;
    logic [31:0] rl, rr;
    sample(lr, so, rdy, und, rv, rl, rr);
    check("rst_lrclk", {31'd0, lr}, 32'd1);
    check("rst_sdout", {31'd0, so}, 32'd0);
    check("rst_tx_ready", {31'd0, rdy}, 32'd0);
    check("rst_underrun", {31'd0, und}, 32'd0);
    check("rst_rx_valid", {31'd0, rv}, 32'd0);
    check("rst_rx_left", rl, 32'd0);
    check("rst_rx_right", rr, 32'd0);
  endtask

  // Hold reset for two cycles (checking outputs), release mid-low-phase.
  task automatic do_reset();
    set_reset(1'b1);
    #1;
    check_reset_vals();
    repeat (2) begin
      @(negedge clk);
      #1;
      check_reset_vals();
    end
    set_reset(1'b0);
    model_clear();
  endtask

  // One bit-clock cycle: compare all outputs against the model, then drive
  // this cycle's inputs and record what the DUT will sample at the next edge.
  task automatic step(input bit loop, input bit vld, input logic [31:0] l,
                      input logic [31:0] r, input bit sbit);
    int          f, s, k, idx;
    logic [63:0] mask, word, hw;
    bit          e_so, e_rv, sin_bit;
    logic        lr, so, rdy, und, rv;
    logic [31:0] rl, rr, lm, rm;

    f    = 2 * w_cur;
    s    = (cyc + f - 1) % f;
    mask = (64'd1 << w_cur) - 64'd1;

    // Bit on the line in slot s: slot 1 is the left MSB of the word accepted
    // one slot earlier; slot 0 is the right LSB of the word from a frame ago.
    k   = (s == 0) ? cyc - f : cyc - s;
    idx = (s == 0) ? 0 : f - s;
    e_so = 1'b0;
    if (tx_hist.exists(k)) begin
      hw   = tx_hist[k];
      e_so = hw[idx];
    end

    e_rv = (s == 1) && (cyc >= f + 2);
    if (e_rv) begin
      word = '0;
      for (int i = 0; i < f; i++) begin
        word[f-1-i] = sin_hist[cyc-f+i];
      end
      exp_rl = 32'((word >> w_cur) & mask);
      exp_rr = 32'(word & mask);
    end

    sample(lr, so, rdy, und, rv, rl, rr);
    check("lrclk", {31'd0, lr}, {31'd0, (s >= w_cur)});
    check("tx_ready", {31'd0, rdy}, {31'd0, (s == 0)});
    check("sdout", {31'd0, so}, {31'd0, e_so});
    check("tx_underrun", {31'd0, und}, {31'd0, exp_und});
    check("rx_valid", {31'd0, rv}, {31'd0, e_rv});
    check("rx_left", rl, exp_rl);
    check("rx_right", rr, exp_rr);

    lm = 32'(l & 32'(mask));
    rm = 32'(r & 32'(mask));
    if (s == 0) begin
      tx_hist[cyc] = vld ? ((64'(lm) << w_cur) | 64'(rm)) : 64'd0;
      if (!vld) exp_und = 1'b1;
    end
    sin_bit       = loop ? e_so : sbit;
    sin_hist[cyc] = sin_bit;

    if (w_cur == 16) begin
      tv16 = vld; tl16 = lm[15:0]; tr16 = rm[15:0]; loop16 = loop; rnd16 = sbit;
    end else begin
      tv8 = vld; tl8 = lm[7:0]; tr8 = rm[7:0]; loop8 = loop; rnd8 = sbit;
    end

    @(negedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout w=%0d cyc=%0d", w_cur, cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic        lr, so, rdy, und, rv;
    logic [31:0] rl, rr;
    logic [31:0] pat16;
    logic [15:0] pat8;

    reset16 = 1'b1; reset8 = 1'b1;
    tl16 = '0; tr16 = '0; tv16 = 1'b0; loop16 = 1'b0; rnd16 = 1'b0;
    tl8  = '0; tr8  = '0; tv8  = 1'b0; loop8  = 1'b0; rnd8  = 1'b0;
    pat16 = 32'hA5C3_1234;
    pat8  = 16'h817E;
    w_cur = 16;
    model_clear();
    @(negedge clk);
    #1;

    // Framing, serialization and loopback at WIDTH=16
    do_reset();
    while (cyc < 100) begin
      if (cyc >= 2 && cyc <= 33) begin
        sample(lr, so, rdy, und, rv, rl, rr);
        check("tp_sdout", {31'd0, so}, {31'd0, pat16[33-cyc]});
      end
      if (cyc == 34 || cyc == 66) begin
        sample(lr, so, rdy, und, rv, rl, rr);
        check("tp_rx_valid", {31'd0, rv}, 32'd1);
        check("tp_rx_left", rl, 32'hA5C3);
        check("tp_rx_right", rr, 32'h1234);
      end
      step(1'b1, 1'b1, 32'hA5C3, 32'h1234, 1'b0);
    end

    // Underrun in the frame accepted at cycle 33
    do_reset();
    while (cyc < 110) begin
      if (cyc == 33) begin
        sample(lr, so, rdy, und, rv, rl, rr);
        check("tp_und_before", {31'd0, und}, 32'd0);
      end
      if (cyc == 34 || cyc == 100) begin
        sample(lr, so, rdy, und, rv, rl, rr);
        check("tp_und_sticky", {31'd0, und}, 32'd1);
      end
      step(1'b1, (cyc != 33), 32'hA5C3, 32'h1234, 1'b0);
    end

    // Mid-frame reset at cycle 10 for three cycles, then random traffic
    do_reset();
    while (cyc < 10) step(1'b0, 1'b1, $urandom, $urandom, 1'($urandom));
    set_reset(1'b1);
    #1;
    check_reset_vals();
    repeat (3) begin
      @(negedge clk);
      #1;
      check_reset_vals();
    end
    set_reset(1'b0);
    model_clear();
    while (cyc < 400) begin
      step(1'b0, ($urandom_range(0, 9) != 0), $urandom, $urandom, 1'($urandom));
    end

    // WIDTH=8: loopback of 0x81 / 0x7E, then random traffic
    w_cur = 8;
    do_reset();
    while (cyc < 60) begin
      if (cyc >= 2 && cyc <= 17) begin
        sample(lr, so, rdy, und, rv, rl, rr);
        check("tp8_sdout", {31'd0, so}, {31'd0, pat8[17-cyc]});
      end
      if (cyc == 18) begin
        sample(lr, so, rdy, und, rv, rl, rr);
        check("tp8_rx_valid", {31'd0, rv}, 32'd1);
        check("tp8_rx_left", rl, 32'h81);
        check("tp8_rx_right", rr, 32'h7E);
      end
      step(1'b1, 1'b1, 32'h81, 32'h7E, 1'b0);
    end
    do_reset();
    while (cyc < 250) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0), $urandom, $urandom,
           1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
